// File: rtl/snake_cmd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | snake_cmd_fifo : toggle-detected HPS command intake into a show-ahead FIFO |
// | Optional macro SNAKE_CMD_OVF_CNT_EN adds the saturating ovf_count output.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module snake_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [6:0]    cmd_in,
  output logic          cmd_valid,
  output logic [5:0]    cmd_data,
  input  logic          cmd_ready,
  output logic [AW:0]   fifo_level,
  output logic          overflow,
  input  logic          ovf_clr
`ifdef SNAKE_CMD_OVF_CNT_EN
  ,
  output logic [7:0]    ovf_count
`endif
);

  localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

  logic            tog_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q,  count_d;
  logic            ovf_q,    ovf_d;
  logic [5:0]      mem_q [DEPTH];

  logic            w_push;
  logic            w_pop;
  logic            w_accept;
  logic            w_drop;

  always_comb begin
    w_push   = (cmd_in[6] != tog_q);
    w_pop    = cmd_valid && cmd_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    w_accept = w_push && ((count_q != C_DEPTH) || w_pop);
    w_drop   = w_push && !w_accept;

    wr_ptr_d = w_accept ? (wr_ptr_q + C_PTR_ONE) : wr_ptr_q;
    rd_ptr_d = w_pop    ? (rd_ptr_q + C_PTR_ONE) : rd_ptr_q;

    count_d = count_q;
    case ({w_accept, w_pop})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase

    ovf_d = ovf_q;
    if (ovf_clr)     ovf_d = 1'b0;
    else if (w_drop) ovf_d = 1'b1;
  end

  // tog_q follows the conduit even in reset so release never looks like a new command.
  always_ff @(posedge clk) begin
    tog_q <= cmd_in[6];
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && w_accept) begin
      mem_q[wr_ptr_q] <= cmd_in[5:0];
    end
  end

  assign cmd_valid  = (count_q != '0);
  assign cmd_data   = mem_q[rd_ptr_q];
  assign fifo_level = count_q;
  assign overflow   = ovf_q;

`ifdef SNAKE_CMD_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_clr)                          ovf_cnt_d = 8'd0;
    else if (w_drop && ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) ovf_cnt_q <= 8'd0;
    else          ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_count = ovf_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_snake_cmd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_snake_cmd_fifo : self-checking bench for snake_cmd_fifo (DEPTH = 8)      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_snake_cmd_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] cmd_in;
  logic       cmd_valid;
  logic [5:0] cmd_data;
  logic       cmd_ready;
  logic [3:0] fifo_level;
  logic       overflow;
  logic       ovf_clr;
`ifdef SNAKE_CMD_OVF_CNT_EN
  logic [7:0] ovf_count;
`endif

  snake_cmd_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_in     (cmd_in),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
`ifdef SNAKE_CMD_OVF_CNT_EN
    ,
    .ovf_count  (ovf_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         tog;
    logic [5:0] pay;
    bit         rdy;
    bit         clr;
    logic [3:0] exp_level;
    bit         exp_valid;
    bit         exp_ovf;
  } vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [5:0] sb_q[$];
  bit         m_ovf;
  int         m_cnt;
  logic [5:0] last_pop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, update the model, then compare after the edge.
  task automatic cycle(input bit tog, input logic [5:0] pay, input bit rdy, input bit clr);
    bit pop;
    cmd_in    = {tog ? ~cmd_in[6] : cmd_in[6], pay};
    cmd_ready = rdy;
    ovf_clr   = clr;
    pop = rdy && (sb_q.size() != 0);
    if (pop) begin
      chk("pop_valid", 32'(cmd_valid), 32'd1);
      chk("pop_data", 32'(cmd_data), 32'(sb_q[0]));
      last_pop = sb_q.pop_front();
    end
    if (tog) begin
      if (sb_q.size() < DEPTH) sb_q.push_back(pay);
      else begin
        m_ovf = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    if (clr) begin
      m_ovf = 1'b0;
      m_cnt = 0;
    end
    @(posedge clk);
    #1;
    chk("level", 32'(fifo_level), 32'(sb_q.size()));
    chk("valid", 32'(cmd_valid), 32'(sb_q.size() != 0));
    if (sb_q.size() != 0) chk("head_data", 32'(cmd_data), 32'(sb_q[0]));
    chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef SNAKE_CMD_OVF_CNT_EN
    chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
`endif
  endtask

  task automatic reset_cycle();
    reset_n   = 1'b0;
    cmd_ready = 1'b0;
    ovf_clr   = 1'b0;
    sb_q.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
`ifdef SNAKE_CMD_OVF_CNT_EN
    chk("rst_ovf_count", 32'(ovf_count), 32'd0);
`endif
  endtask

  initial begin
    vec_t tbl[18];
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 6'(i + 1), 1'b0, 1'b0, 4'(i + 1), 1'b1, 1'b0};
    tbl[8] = '{1'b1, 6'h09, 1'b0, 1'b0, 4'd8, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++)
      tbl[9 + i] = '{1'b0, 6'h00, 1'b1, 1'b0, 4'(7 - i), (i != 7), 1'b1};
    tbl[17] = '{1'b0, 6'h00, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};

    reset_n   = 1'b0;
    cmd_in    = 7'h40;
    cmd_ready = 1'b0;
    ovf_clr   = 1'b0;
    m_ovf     = 1'b0;
    m_cnt     = 0;
    last_pop  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_cycle();

    // Held conduit after reset release must not push.
    for (int i = 0; i < 20; i++) cycle(1'b0, 6'h00, 1'b0, 1'b0);

    cycle(1'b1, 6'h05, 1'b0, 1'b0);
    chk("first_data", 32'(cmd_data), 32'h05);
    cycle(1'b0, 6'h05, 1'b1, 1'b0);
    chk("first_drain_level", 32'(fifo_level), 32'd0);

    // Fill, drop on full, drain in order, clear overflow.
    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].tog, tbl[i].pay, tbl[i].rdy, tbl[i].clr);
      chk("tbl_level", 32'(fifo_level), 32'(tbl[i].exp_level));
      chk("tbl_valid", 32'(cmd_valid), 32'(tbl[i].exp_valid));
      chk("tbl_overflow", 32'(overflow), 32'(tbl[i].exp_ovf));
    end
    chk("tbl_last_pop", 32'(last_pop), 32'h08);

    // Reset with entries queued and overflow set.
    for (int i = 0; i < 9; i++) cycle(1'b1, 6'(i + 16), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 6'h00, 1'b1, 1'b0);
    chk("pre_rst_level", 32'(fifo_level), 32'd5);
    reset_cycle();
    cycle(1'b1, 6'h2A, 1'b0, 1'b0);
    chk("post_rst_data", 32'(cmd_data), 32'h2A);
    cycle(1'b0, 6'h00, 1'b1, 1'b0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 8; i++) cycle(1'b1, 6'(i + 1), 1'b0, 1'b0);
    cycle(1'b1, 6'h09, 1'b1, 1'b0);
    chk("swap_level", 32'(fifo_level), 32'd8);
    chk("swap_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 6'h00, 1'b1, 1'b0);
    chk("swap_last_pop", 32'(last_pop), 32'h09);

    // Clear wins over a same-cycle drop.
    for (int i = 0; i < 8; i++) cycle(1'b1, 6'(i + 32), 1'b0, 1'b0);
    cycle(1'b1, 6'h3F, 1'b0, 1'b1);
    chk("clr_prio_overflow", 32'(overflow), 32'd0);
`ifdef SNAKE_CMD_OVF_CNT_EN
    for (int i = 0; i < 260; i++) cycle(1'b1, 6'h11, 1'b0, 1'b0);
    chk("ovf_count_sat", 32'(ovf_count), 32'd255);
    cycle(1'b0, 6'h00, 1'b0, 1'b1);
`endif
    for (int i = 0; i < 8; i++) cycle(1'b0, 6'h00, 1'b1, 1'b0);
    chk("end_valid", 32'(cmd_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
